// File: rtl/ym3438_lfo_mc.sv
// Multi-channel LFO with a time-multiplexed slot port returning AM level and
// PM-modulated fnum for one channel per request, two clocks after acceptance.
module ym3438_lfo_mc #(
  parameter int NCH    = 6,
  parameter int CH_W   = 3,
  parameter int FNUM_W = 11
) (
  input  logic              MCLK,
  input  logic              IC,
  input  logic              tick,
  input  logic [NCH-1:0]    lfo_en,
  input  logic [3*NCH-1:0]  lfo_rate,
  input  logic [2*NCH-1:0]  lfo_wave,
  input  logic [NCH-1:0]    lfo_sync,
  input  logic              slot_valid,
  input  logic [CH_W-1:0]   slot_ch,
  input  logic [FNUM_W-1:0] slot_fnum,
  input  logic [2:0]        slot_pms,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [FNUM_W:0]   out_fnum_lfo,
  output logic [5:0]        out_am,
  output logic [NCH-1:0]    wrap
);

  localparam int PW = FNUM_W + 4;  // (FNUM_W-4) + 3 + 5 product bits
  localparam int SW = FNUM_W + 5;
  localparam logic [SW-1:0] MAXV = SW'({(FNUM_W+1){1'b1}});

  function automatic logic [6:0] thr_of(input logic [2:0] r);
    case (r)
      3'd0:    thr_of = 7'd108;
      3'd1:    thr_of = 7'd77;
      3'd2:    thr_of = 7'd71;
      3'd3:    thr_of = 7'd67;
      3'd4:    thr_of = 7'd62;
      3'd5:    thr_of = 7'd44;
      3'd6:    thr_of = 7'd8;
      default: thr_of = 7'd5;
    endcase
  endfunction

  function automatic logic [4:0] pms_mul(input logic [2:0] s);
    case (s)
      3'd0:    pms_mul = 5'd0;
      3'd1:    pms_mul = 5'd1;
      3'd2:    pms_mul = 5'd2;
      3'd3:    pms_mul = 5'd3;
      3'd4:    pms_mul = 5'd4;
      3'd5:    pms_mul = 5'd6;
      3'd6:    pms_mul = 5'd12;
      default: pms_mul = 5'd24;
    endcase
  endfunction

  logic [6:0] subcnt [NCH];
  logic [6:0] p      [NCH];

  always_ff @(posedge MCLK) begin
    if (IC) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        subcnt[k] <= '0;
        p[k]      <= '0;
      end
      wrap <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        wrap[k] <= 1'b0;
        if (lfo_sync[k] || !lfo_en[k]) begin
          subcnt[k] <= '0;
          p[k]      <= '0;
        end else if (tick) begin
          // >= so a rate lowered below the running count still wraps next tick
          if (subcnt[k] >= thr_of(lfo_rate[3*k +: 3])) begin
            subcnt[k] <= '0;
            p[k]      <= p[k] + 7'd1;
            wrap[k]   <= (p[k] == 7'h7F);
          end else begin
            subcnt[k] <= subcnt[k] + 7'd1;
          end
        end
      end
    end
  end

  logic       ch_ok;
  logic [6:0] sel_p;
  logic [1:0] sel_wave;

  always_comb begin
    ch_ok    = 1'b0;
    sel_p    = '0;
    sel_wave = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (slot_ch == CH_W'(k)) begin
        ch_ok    = 1'b1;
        sel_p    = p[k];
        sel_wave = lfo_wave[2*k +: 2];
      end
    end
  end

  logic              s1_valid;
  logic [CH_W-1:0]   s1_ch;
  logic [FNUM_W-1:0] s1_fnum;
  logic [2:0]        s1_pms;
  logic [6:0]        s1_p;
  logic [1:0]        s1_wave;

  always_ff @(posedge MCLK) begin
    if (IC) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_fnum  <= '0;
      s1_pms   <= '0;
      s1_p     <= '0;
      s1_wave  <= '0;
    end else begin
      s1_valid <= slot_valid && ch_ok;
      if (slot_valid && ch_ok) begin
        s1_ch   <= slot_ch;
        s1_fnum <= slot_fnum;
        s1_pms  <= slot_pms;
        s1_p    <= sel_p;
        s1_wave <= sel_wave;
      end
    end
  end

  logic [5:0]      am;
  logic [2:0]      mag;
  logic            sign;
  logic [PW-1:0]   prod;
  logic [SW-1:0]   base_x;
  logic [SW-1:0]   off_x;
  logic [SW-1:0]   sum_x;
  logic [FNUM_W:0] fnum_res;

  always_comb begin
    sign = s1_p[6];
    case (s1_wave)
      2'd1: begin
        am  = ~s1_p[6:1];
        mag = s1_p[5:3];
      end
      2'd2: begin
        am  = s1_p[6] ? '0 : '1;
        mag = 3'd7;
      end
      default: begin
        am  = ~(s1_p[5:0] ^ {6{s1_p[6]}});
        mag = s1_p[4:2] ^ {3{s1_p[5]}};
      end
    endcase
    prod   = PW'(s1_fnum[FNUM_W-1:4]) * PW'(mag) * PW'(pms_mul(s1_pms));
    base_x = SW'({s1_fnum, 1'b0});
    off_x  = SW'(prod >> 5);
    sum_x  = base_x + off_x;
    if (!sign)
      fnum_res = (sum_x > MAXV) ? '1 : sum_x[FNUM_W:0];
    else if (off_x > base_x)
      fnum_res = '0;
    else
      fnum_res = base_x[FNUM_W:0] - off_x[FNUM_W:0];
  end

  always_ff @(posedge MCLK) begin
    if (IC) begin
      out_valid    <= 1'b0;
      out_ch       <= '0;
      out_fnum_lfo <= '0;
      out_am       <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ch       <= s1_ch;
        out_fnum_lfo <= fnum_res;
        out_am       <= am;
      end
    end
  end

endmodule

// File: tb/tb_ym3438_lfo_mc.sv
// Bench for ym3438_lfo_mc: directed vector table, hand-written corner sequences,
// and random stimulus checked every cycle against an arithmetic reference model.
module tb_ym3438_lfo_mc;
  localparam int NCH = 6;
  localparam int CH_W = 3;
  localparam int FNUM_W = 11;

  logic              MCLK = 1'b0;
  logic              IC = 1'b1;
  logic              tick = 1'b0;
  logic [NCH-1:0]    lfo_en = '0;
  logic [3*NCH-1:0]  lfo_rate = '0;
  logic [2*NCH-1:0]  lfo_wave = '0;
  logic [NCH-1:0]    lfo_sync = '0;
  logic              slot_valid = 1'b0;
  logic [CH_W-1:0]   slot_ch = '0;
  logic [FNUM_W-1:0] slot_fnum = '0;
  logic [2:0]        slot_pms = '0;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [FNUM_W:0]   out_fnum_lfo;
  logic [5:0]        out_am;
  logic [NCH-1:0]    wrap;

  ym3438_lfo_mc #(.NCH(NCH), .CH_W(CH_W), .FNUM_W(FNUM_W)) dut (
    .MCLK(MCLK), .IC(IC), .tick(tick), .lfo_en(lfo_en), .lfo_rate(lfo_rate),
    .lfo_wave(lfo_wave), .lfo_sync(lfo_sync), .slot_valid(slot_valid),
    .slot_ch(slot_ch), .slot_fnum(slot_fnum), .slot_pms(slot_pms),
    .out_valid(out_valid), .out_ch(out_ch), .out_fnum_lfo(out_fnum_lfo),
    .out_am(out_am), .wrap(wrap)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;

  int thr_tab [8] = '{108, 77, 71, 67, 62, 44, 8, 5};
  int mul_tab [8] = '{0, 1, 2, 3, 4, 6, 12, 24};

  // reference state
  int m_sub [NCH];
  int m_p   [NCH];
  logic [NCH-1:0] m_wrap;
  bit s1v;
  int s1ch, s1fnum, s1pms, s1p, s1wave;
  bit e_valid;
  int e_ch, e_fnum, e_am;

  function automatic void ref_eval(input int wave, input int p, input int fnum,
                                   input int pms, output int am, output int fo);
    int mag, off, base, m5, a;
    if (wave == 1) begin
      am  = 63 - p / 2;
      mag = (p % 64) / 8;
    end else if (wave == 2) begin
      am  = (p < 64) ? 63 : 0;
      mag = 7;
    end else begin
      a   = (p < 64) ? (p % 64) : 63 - (p % 64);
      am  = 63 - a;
      m5  = (p % 32) / 4;
      mag = ((p / 32) % 2 == 1) ? 7 - m5 : m5;
    end
    off  = ((fnum / 16) * mag * mul_tab[pms]) / 32;
    base = 2 * fnum;
    if (p >= 64) fo = (base - off < 0) ? 0 : base - off;
    else         fo = (base + off > 4095) ? 4095 : base + off;
  endfunction

  task automatic model_step();
    int am, fo;
    if (IC) begin
      e_valid = 0; e_ch = 0; e_fnum = 0; e_am = 0; s1v = 0;
      for (int k = 0; k < NCH; k++) begin m_sub[k] = 0; m_p[k] = 0; end
      m_wrap = '0;
      return;
    end
    e_valid = s1v;
    if (s1v) begin
      ref_eval(s1wave, s1p, s1fnum, s1pms, am, fo);
      e_ch = s1ch; e_fnum = fo; e_am = am;
    end
    s1v = slot_valid && (int'(slot_ch) < NCH);
    if (s1v) begin
      s1ch = int'(slot_ch); s1fnum = int'(slot_fnum); s1pms = int'(slot_pms);
      s1p = m_p[s1ch]; s1wave = int'(lfo_wave[2*s1ch +: 2]);
    end
    for (int k = 0; k < NCH; k++) begin
      m_wrap[k] = 1'b0;
      if (lfo_sync[k] || !lfo_en[k]) begin
        m_sub[k] = 0; m_p[k] = 0;
      end else if (tick) begin
        if (m_sub[k] >= thr_tab[lfo_rate[3*k +: 3]]) begin
          m_sub[k] = 0;
          if (m_p[k] == 127) m_wrap[k] = 1'b1;
          m_p[k] = (m_p[k] + 1) % 128;
        end else m_sub[k] = m_sub[k] + 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge MCLK);
    model_step();
    #1;
    checks++;
    if (out_valid !== e_valid || wrap !== m_wrap ||
        (e_valid && (int'(out_ch) != e_ch || int'(out_fnum_lfo) != e_fnum ||
                     int'(out_am) != e_am))) begin
      errors++;
      $display("FAIL model: got v=%0b ch=%0d fnum=%0d am=%0d wrap=%b expected v=%0b ch=%0d fnum=%0d am=%0d wrap=%b at %0t",
               out_valid, out_ch, out_fnum_lfo, out_am, wrap,
               e_valid, e_ch, e_fnum, e_am, m_wrap, $time);
    end
  endtask

  task automatic slot(input int ch, input int fnum, input int pms);
    slot_valid = 1'b1; slot_ch = CH_W'(ch);
    slot_fnum = FNUM_W'(fnum); slot_pms = 3'(pms);
  endtask

  task automatic sync_ch(input int ch, input int rate, input int wave);
    lfo_en[ch] = 1'b1; lfo_rate[3*ch +: 3] = 3'(rate); lfo_wave[2*ch +: 2] = 2'(wave);
    lfo_sync[ch] = 1'b1; cycle(); lfo_sync[ch] = 1'b0;
  endtask

  typedef struct {
    int ch; int wave; int p; int fnum; int pms; int am; int fo;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 0,  0, 'h400, 7, 63, 2048};
    vecs[1] = '{0, 0,  1, 'h400, 7, 62, 2048};
    vecs[2] = '{0, 0, 24, 'h400, 7, 39, 2336};
    vecs[3] = '{0, 0, 28, 'h7FF, 7, 35, 4095};
    vecs[4] = '{0, 0, 92, 'h010, 7, 28,   27};
    vecs[5] = '{1, 2, 64, 'h400, 7,  0, 1712};
    vecs[6] = '{1, 1, 10, 'h400, 3, 58, 2054};

    // reset
    IC = 1'b1; cycle(); cycle();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_am", int'(out_am), 0);
    chk("rst_fnum", int'(out_fnum_lfo), 0);
    chk("rst_wrap", int'(wrap), 0);
    IC = 1'b0;
    slot(0, 'h155, 5); cycle(); slot_valid = 1'b0;
    chk("rst_lat1", int'(out_valid), 0);
    cycle();
    chk("rst_slot_valid", int'(out_valid), 1);
    chk("rst_slot_am", int'(out_am), 63);
    chk("rst_slot_fnum", int'(out_fnum_lfo), 'h2AA);
    cycle();
    chk("rst_slot_pulse", int'(out_valid), 0);

    // vector table: rate 7, p*6 ticks from sync
    foreach (vecs[i]) begin
      sync_ch(vecs[i].ch, 7, vecs[i].wave);
      tick = 1'b1; repeat (vecs[i].p * 6) cycle(); tick = 1'b0;
      slot(vecs[i].ch, vecs[i].fnum, vecs[i].pms); cycle(); slot_valid = 1'b0; cycle();
      chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("vec%0d_ch", i), int'(out_ch), vecs[i].ch);
      chk($sformatf("vec%0d_am", i), int'(out_am), vecs[i].am);
      chk($sformatf("vec%0d_fnum", i), int'(out_fnum_lfo), vecs[i].fo);
    end

    // full period wrap on ch0 at rate 7
    sync_ch(0, 7, 0);
    tick = 1'b1; repeat (767) cycle();
    chk("wrap_early", int'(wrap[0]), 0);
    cycle();
    chk("wrap_pulse", int'(wrap[0]), 1);
    tick = 1'b0; cycle();
    chk("wrap_end", int'(wrap[0]), 0);
    slot(0, 'h400, 7); cycle(); slot_valid = 1'b0; cycle();
    chk("wrap_p0_am", int'(out_am), 63);

    // sync + tick + slot same cycle at p=5
    sync_ch(0, 7, 0);
    tick = 1'b1; repeat (30) cycle();
    lfo_sync[0] = 1'b1; slot(0, 'h400, 7); cycle();
    lfo_sync[0] = 1'b0; tick = 1'b0; cycle();
    chk("coll_am", int'(out_am), 58);
    chk("coll_fnum", int'(out_fnum_lfo), 2096);
    slot_valid = 1'b0; cycle();
    chk("coll_next_am", int'(out_am), 63);
    chk("coll_next_fnum", int'(out_fnum_lfo), 2048);
    tick = 1'b1; repeat (5) cycle(); tick = 1'b0;
    slot(0, 'h400, 7); cycle(); slot_valid = 1'b0; cycle();
    chk("coll_sub0_am", int'(out_am), 63);

    // out-of-range channel
    slot(NCH, 'h400, 7); cycle(); slot_valid = 1'b0; cycle();
    chk("badch_valid", int'(out_valid), 0);
    cycle();
    chk("badch_valid2", int'(out_valid), 0);

    // reset while a result is in flight
    slot(0, 'h123, 2); cycle(); slot_valid = 1'b0; IC = 1'b1; cycle(); IC = 1'b0;
    chk("ic_drop", int'(out_valid), 0);
    cycle();
    chk("ic_drop2", int'(out_valid), 0);

    // randomized run against the model
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(99) == 0) lfo_en[k] = ~lfo_en[k];
        if ($urandom_range(199) == 0) lfo_rate[3*k +: 3] = 3'($urandom_range(7));
        if ($urandom_range(199) == 0) lfo_wave[2*k +: 2] = 2'($urandom_range(3));
        lfo_sync[k] = ($urandom_range(149) == 0);
      end
      if (n == 0) begin lfo_en = '1; lfo_rate = '1; end
      tick = ($urandom_range(3) != 0);
      IC = ($urandom_range(499) == 0);
      slot_valid = $urandom_range(1) == 1;
      slot_ch = CH_W'($urandom_range(7));
      slot_fnum = FNUM_W'($urandom);
      slot_pms = 3'($urandom_range(7));
      cycle();
    end
    IC = 1'b0; slot_valid = 1'b0; cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
